gate_bist_driver: RTL and testbench
===================================

# gate_bist_driver

Self-test initiator for the two-input gate primitives in the operations library. It drives all four {A,B} input combinations into an external gate under test (DUT) and waits a programmable settle time per vector. It samples the DUT output and compares it against the expected truth table for a selected operation. It reports pass/fail, an error count and the first failing vector, and sits beside the gate library as its built-in self-test stimulus and checker.

## Interface
- SETTLE, default 2: extra cycles each vector is held before sampling; each vector lasts SETTLE+1 cycles; range 0..255.
- LOOPS, default 1: number of full 4-vector sweeps per run; range 1..65535.

- CLK  in  1  rising-edge clock.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  run request; sampled only in IDLE.
- OP  in  2  operation under test: 00 AND, 01 OR, 10 XOR, 11 NAND; latched on accepted START.
- DUT_A  out  1  stimulus to DUT input A.
- DUT_B  out  1  stimulus to DUT input B.
- DUT_OUT  in  1  DUT output, sampled by the block.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  one-cycle pulse at run completion.
- PASS  out  1  1 if the last completed run had zero mismatches; held until the next accepted START.
- ERR_CNT  out  8  mismatch count of the current or last run, saturating at 255.
- FAIL_VEC  out  2  {A,B} of the first mismatch in the run; valid when ERR_CNT != 0.

## Operation
- States: IDLE, RUN.
- IDLE, START=1: latch OP; clear ERR_CNT, FAIL_VEC and PASS; set vec=0, settle counter=SETTLE, loop counter=0; drive {DUT_A,DUT_B}=00; BUSY=1; go to RUN.
- RUN, settle counter != 0: decrement it and hold the vector.
- RUN, settle counter == 0: sample DUT_OUT and compare it with the expected value for the latched OP at the current vec.
  - On mismatch: ERR_CNT+1 (saturating at 255). If this is the first mismatch of the run, FAIL_VEC=vec.
  - Then advance vec 00→01→10→11 and reload the settle counter.
  - At vec=11: wrap to 00 and increment the loop counter.
- Last sample of the last loop: go to IDLE, DONE=1 for one cycle, BUSY=0, DUT_A/DUT_B=0. PASS=1 if no mismatch occurred, including the final sample.
- START while BUSY is ignored. OP changes during RUN are ignored.
- START in the DONE cycle is accepted, because the state is already IDLE.
- Expected values: AND a&b, OR a|b, XOR a^b, NAND ~(a&b).

## Timing
- Reset values: DUT_A=0, DUT_B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=00, state IDLE, all counters 0.
- RST asserted mid-run aborts the run in the next cycle. DONE is not pulsed and results are cleared.
- Cycle numbering: START is sampled at edge 0, and cycle n follows edge n.
- Vector k of the run (k = 0 .. 4·LOOPS−1) is visible in cycles k(SETTLE+1) .. k(SETTLE+1)+SETTLE.
- DUT_OUT for vector k is sampled at edge (k+1)(SETTLE+1).
- DONE is high in cycle 4·LOOPS·(SETTLE+1). With defaults this is cycle 12.
- START held high gives back-to-back runs with period 4·LOOPS·(SETTLE+1)+1 cycles.
- All outputs are registered. There is no combinational path from DUT_OUT or START to any output.

## Structure
- Shared package/header ops_defs: OP code constants (OP_AND, OP_OR, OP_XOR, OP_NAND), state encoding, and ERR_CNT width constant (8).
- One sub-module, op_expect: combinational reference model. Inputs OP, A, B; output expected OUT. It is reused by other library checkers.
- Loop counter width: clog2(LOOPS+1). Settle counter width: 8.

## Test plan
- Reset check: hold RST for 3 cycles, then release → all outputs 0, BUSY=0, and no DONE for 20 idle cycles.
- AND DUT, OP=00, defaults, START at edge 0 → {DUT_A,DUT_B} = 00,01,10,11, each for 3 cycles; DONE in cycle 12; PASS=1; ERR_CNT=0.
- Wrong operation: DUT is AND but OP=01 → mismatches at vectors 01 and 10; ERR_CNT=2, FAIL_VEC=01, PASS=0.
- DUT_OUT stuck at 1, OP=11 → one mismatch per sweep at vector 11.
  - LOOPS=100: ERR_CNT=100.
  - LOOPS=300: ERR_CNT=255 (saturated), FAIL_VEC=11.
- Pulse RST at cycle 5 mid-run → next cycle BUSY=0 and DUT_A/DUT_B=0, with no DONE. Separately, toggle START and OP during BUSY → no restart and results unchanged.
- START held high, AND DUT, defaults → DONE pulses in cycles 12, 25, 38, with PASS=1 each time.

Source files
------------

// File: rtl/ops_defs.sv
// ops_defs: shared op codes, FSM states and widths for the gate library checkers
package ops_defs;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;
    localparam int ERR_W = 8;
    typedef enum logic {S_IDLE, S_RUN} state_t;
endpackage

// File: rtl/op_expect.sv
// op_expect: combinational truth-table reference for the two-input gate ops
module op_expect
    import ops_defs::*;
(
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       out
);
    // select the reference result for the requested operation
    always_comb begin
        out = (op == OP_AND) ? (a & b) :
              (op == OP_OR)  ? (a | b) :
              (op == OP_XOR) ? (a ^ b) : ~(a & b);
    end
endmodule

// File: rtl/gate_bist_driver.sv
// gate_bist_driver: sweeps all {a,b} vectors into a gate and checks its output
module gate_bist_driver
    import ops_defs::*;
#(
    parameter int SETTLE = 2,
    parameter int LOOPS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       fail_vec
);
    localparam int LW = $clog2(LOOPS + 1);

    state_t          state, state_nx;
    logic [1:0]      op_q, vec;
    logic [7:0]      settle;
    logic [LW-1:0]   loops;
    logic            exp_out, sample, mism, last;

    op_expect u_exp (.op(op_q), .a(vec[1]), .b(vec[0]), .out(exp_out));

    assign dut_a = vec[1];
    assign dut_b = vec[0];

    // sample strobe, mismatch, end-of-run detection and next state
    always_comb begin
        sample   = (state == S_RUN) && (settle == 8'd0);
        mism     = sample && (dut_out != exp_out);
        last     = sample && (vec == 2'b11) && (loops == LW'(LOOPS - 1));
        state_nx = (state == S_IDLE) ? (start ? S_RUN : S_IDLE) : (last ? S_IDLE : S_RUN);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // vector sequencing, settle/loop counting and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_AND;
            vec      <= 2'b00;
            settle   <= 8'd0;
            loops    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= 2'b00;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start) begin
                op_q     <= op;
                vec      <= 2'b00;
                settle   <= 8'(SETTLE);
                loops    <= '0;
                busy     <= 1'b1;
                pass     <= 1'b0;
                err_cnt  <= '0;
                fail_vec <= 2'b00;
            end else if (state == S_RUN) begin
                if (!sample) begin
                    settle <= settle - 8'd1;
                end else begin
                    if (mism && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
                    if (mism && err_cnt == '0) fail_vec <= vec;
                    vec    <= vec + 2'd1;
                    settle <= 8'(SETTLE);
                    if (vec == 2'b11) loops <= loops + 1'b1;
                    if (last) begin
                        vec  <= 2'b00;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !mism && (err_cnt == '0);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gate_bist_driver.sv
// tb_gate_bist_driver: scoreboard bench for the gate BIST driver
module tb_gate_bist_driver;
    typedef struct packed {
        logic [7:0] err;
        logic [1:0] fv;
        logic       pass;
    } res_t;

    logic clk, rst;
    logic start0, mode0, a0, b0, out0, busy0, done0, pass0;
    logic [1:0] op0, fv0;
    logic [7:0] err0;
    logic start1, a1, b1, busy1, done1, pass1;
    logic [1:0] fv1;
    logic [7:0] err1;
    logic start2, a2, b2, busy2, done2, pass2;
    logic [1:0] fv2;
    logic [7:0] err2;

    res_t q0[$], q1[$], q2[$];
    int n_chk = 0, n_fail = 0;

    assign out0 = mode0 ? 1'b1 : (a0 & b0);

    gate_bist_driver u0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0), .dut_a(a0), .dut_b(b0),
        .dut_out(out0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
    );
    gate_bist_driver #(.LOOPS(100)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op(2'b11), .dut_a(a1), .dut_b(b1),
        .dut_out(1'b1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );
    gate_bist_driver #(.LOOPS(300)) u2 (
        .clk(clk), .rst(rst), .start(start2), .op(2'b11), .dut_a(a2), .dut_b(b2),
        .dut_out(1'b1), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input res_t e, input logic [7:0] err,
                       input logic [1:0] fv, input logic p);
        check({tag, " err_cnt"}, 32'(err), 32'(e.err));
        check({tag, " fail_vec"}, 32'(fv), 32'(e.fv));
        check({tag, " pass"}, 32'(p), 32'(e.pass));
    endtask

    always @(negedge clk) if (done0) begin
        check("u0 sb depth", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) cmp("u0", q0.pop_front(), err0, fv0, pass0);
    end
    always @(negedge clk) if (done1) begin
        check("u1 sb depth", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) cmp("u1", q1.pop_front(), err1, fv1, pass1);
    end
    always @(negedge clk) if (done2) begin
        check("u2 sb depth", 32'(q2.size() > 0), 1);
        if (q2.size() > 0) cmp("u2", q2.pop_front(), err2, fv2, pass2);
    end

    task automatic wait_done0(input string tag, input int lim);
        int c = 0;
        while (!done0 && c < lim) begin
            @(negedge clk);
            c++;
        end
        check({tag, " done seen"}, 32'(done0), 1);
        @(negedge clk);
    endtask

    task automatic run0(input string tag, input logic [1:0] op, input logic mode, input res_t e);
        q0.push_back(e);
        op0 = op;
        mode0 = mode;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(tag, 100);
    endtask

    task automatic idle_no_done(input string tag);
        int dn = 0;
        repeat (20) begin
            @(negedge clk);
            dn += int'(done0);
        end
        check(tag, 32'(dn), 0);
    endtask

    initial begin
        int c, k;
        int dc[3];
        rst = 1'b1;
        start0 = 1'b0; op0 = 2'b00; mode0 = 1'b0;
        start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset outs", {a0, b0, busy0, done0, pass0, err0, fv0}, 0);
        check("reset others", {busy1, busy2, a1, b1, a2, b2}, 0);
        idle_no_done("reset idle done count");

        q0.push_back('{8'd0, 2'd0, 1'b1});
        op0 = 2'b00; mode0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            check($sformatf("and cyc%0d", i), {busy0, done0, a0, b0},
                  (i < 12) ? {2'b10, 2'(i / 3)} : 4'b0100);
            if (i < 12) @(negedge clk);
        end
        @(negedge clk);

        run0("wrong op", 2'b01, 1'b0, '{8'd2, 2'd1, 1'b0});

        q1.push_back('{8'd100, 2'd3, 1'b0});
        q2.push_back('{8'd255, 2'd3, 1'b0});
        start1 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        c = 0;
        while (!done1 && c < 2000) begin @(negedge clk); c++; end
        check("u1 done seen", 32'(done1), 1);
        c = 0;
        while (!done2 && c < 4000) begin @(negedge clk); c++; end
        check("u2 done seen", 32'(done2), 1);
        @(negedge clk);

        op0 = 2'b00; mode0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-abort vec", {busy0, a0, b0}, 3'b101);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort outs", {busy0, done0, a0, b0, pass0, err0, fv0}, 0);
        idle_no_done("abort no done");

        q0.push_back('{8'd0, 2'd0, 1'b1});
        op0 = 2'b00; mode0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            start0 = i[0];
            op0 = 2'(i);
        end
        @(negedge clk);
        start0 = 1'b0;
        check("ignore done cyc12", 32'(done0), 1);
        idle_no_done("ignore no restart");

        repeat (3) q0.push_back('{8'd0, 2'd0, 1'b1});
        op0 = 2'b00; mode0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        c = 0; k = 0;
        while (k < 3 && c < 60) begin
            if (done0) begin dc[k] = c; k++; end
            if (k < 3) begin @(negedge clk); c++; end
        end
        start0 = 1'b0;
        check("held done count", 32'(k), 3);
        check("held done0 cyc", 32'(dc[0]), 12);
        check("held done1 cyc", 32'(dc[1]), 25);
        check("held done2 cyc", 32'(dc[2]), 38);
        idle_no_done("held stop");

        check("q0 drained", 32'(q0.size()), 0);
        check("q1 drained", 32'(q1.size()), 0);
        check("q2 drained", 32'(q2.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
